packet_stream_arbiter: RTL and testbench
========================================

Name: packet_stream_arbiter

Overview:
- Round-robin, packet-granular arbiter that shares one byte stream (valid/ready/last) among SOURCE_COUNT requesters.
- Typical use: merging result packets from several processor_controller/processor lanes into the single packet_constructor → uart_controller egress path.
- Once a source is granted, the grant is held until that source's last byte is accepted, so packets never interleave.
- Optionally prepends a one-byte source tag to each packet so the host can demultiplex.

Parameters:
- SOURCE_COUNT, 3: number of requester streams (≥2).
- DATA_WIDTH, 8: byte width of each stream.
- TAG_ENABLE, 1: 1 = emit a tag byte before each packet; 0 = no tag.
- TAG_BASE, 8'hA0: tag byte = TAG_BASE | granted index. Low $clog2(SOURCE_COUNT) bits of TAG_BASE must be zero.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- in_data  in  DATA_WIDTH*SOURCE_COUNT  concatenated source bytes; source i occupies bits [DATA_WIDTH*i +: DATA_WIDTH]
- in_valid  in  SOURCE_COUNT  per-source valid
- in_ready  out  SOURCE_COUNT  per-source ready
- in_last  in  SOURCE_COUNT  per-source end-of-packet marker
- out_data  out  DATA_WIDTH  merged stream data
- out_valid  out  1  merged stream valid
- out_ready  in  1  downstream ready
- out_last  out  1  end of merged packet
- grant_index  out  $clog2(SOURCE_COUNT)  currently or most recently granted source
- busy  out  1  high when in TAG or STREAM state

Behaviour:
- Handshake: a beat transfers on a cycle where valid && ready. Sources must hold data, valid and last stable until their beat is accepted.
- Reset (synchronous): state=IDLE, grant_index=SOURCE_COUNT-1 (so source 0 wins the first arbitration), busy=0, out_valid=0, in_ready=0.
- FSM states: IDLE, TAG, STREAM.
- IDLE:
  - out_valid=0, in_ready all 0.
  - If any in_valid bit is set, select the first valid source searching upward from grant_index+1, modulo SOURCE_COUNT.
  - Register the selection into grant_index.
  - Next state: TAG if TAG_ENABLE, else STREAM.
  - Arbitration costs one idle cycle per packet.
- TAG:
  - out_valid=1, out_data=TAG_BASE|grant_index, out_last=0, in_ready all 0.
  - On out_ready → STREAM.
  - The tag is emitted even if the granted source has deasserted valid.
- STREAM:
  - Combinational passthrough of the granted source: out_data, out_valid and out_last follow the granted lane; in_ready[grant_index]=out_ready; all other in_ready bits = 0.
  - No added latency in this state.
  - On out_valid && out_ready && out_last → IDLE.
- grant_index changes only on the IDLE→TAG or IDLE→STREAM transition and is stable for the whole packet.
- Fairness:
  - With all sources continuously requesting, the grant order is 0,1,2,0,1,2,…
  - A source waits at most SOURCE_COUNT-1 packets.
  - Non-requesting sources are skipped with no extra cycles.
- Boundary conditions:
  - Single-byte packet (last on the first beat): TAG (if enabled), one data beat, then IDLE.
  - Granted source stalls (valid=0) in STREAM: out_valid=0, grant held indefinitely, no timeout.
  - out_ready low: all state holds and out_data/out_valid stay stable (the tag byte comes from a register).
  - A source asserting in_last with in_valid=0 has no effect.
  - Valid on a non-granted lane mid-packet: ignored (its in_ready stays 0) until arbitration.
  - Reset mid-packet: return to IDLE immediately; any remaining bytes of the interrupted source are later treated as a new packet.
- Width: the grant search uses modulo-SOURCE_COUNT wrap and must be correct for non-power-of-two SOURCE_COUNT (e.g. 3: index 2 wraps to 0, never to 3).

Test Plan:
- Reset, then only source 1 sends a 2-byte packet 11,12 (last on 12) → out: A1, 11, 12 (last on 12); grant_index=1; busy falls the cycle after 12 is accepted.
- All 3 sources hold 1-byte packets (0x10, 0x20, 0x30) continuously valid → out sequence A0,10,A1,20,A2,30,A0,10…; exactly one idle cycle between packets.
- Source 0 sends a 3-byte packet 01,02,03 while source 2 is valid → source 2 sees in_ready=0 until 03 is accepted; next packet is A2 followed by source 2's data.
- out_ready toggles 1,0,1,0 during a 4-byte packet → no byte lost or duplicated; out_data stable while stalled, including on the tag byte.
- TAG_ENABLE=0, SOURCE_COUNT=3, grant_index=2, sources 0 and 2 valid → source 0 granted (wrap); no tag byte emitted.
- Reset asserted after 2 of 4 bytes from source 1 → next cycle state=IDLE, in_ready=0, grant_index=2; remaining bytes are re-arbitrated as a new packet (tag A1 if source 1 wins).

Source files
------------

// File: rtl/packet_stream_arbiter.sv
// Round-robin, packet-granular arbiter merging SOURCE_COUNT valid/ready/last byte
// streams onto one output; the grant is held until the granted packet's last beat.
module packet_stream_arbiter #(
    parameter int unsigned           SOURCE_COUNT = 3,
    parameter int unsigned           DATA_WIDTH   = 8,
    parameter bit                    TAG_ENABLE   = 1'b1,
    parameter logic [DATA_WIDTH-1:0] TAG_BASE     = 8'hA0
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [DATA_WIDTH*SOURCE_COUNT-1:0] in_data,
    input  logic [SOURCE_COUNT-1:0]            in_valid,
    output logic [SOURCE_COUNT-1:0]            in_ready,
    input  logic [SOURCE_COUNT-1:0]            in_last,
    output logic [DATA_WIDTH-1:0]              out_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic                               out_last,
    output logic [$clog2(SOURCE_COUNT)-1:0]    grant_index,
    output logic                               busy
);

    localparam int unsigned GW = $clog2(SOURCE_COUNT);

    typedef enum logic [1:0] {
        IDLE,
        TAG,
        STREAM
    } state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   pick;
    logic            pick_found;
    logic [GW-1:0]   cand;
    int unsigned     idx;
    logic [DATA_WIDTH-1:0] tag_byte;

    // Search upward from the last grant with modulo wrap; the last grant itself is
    // visited last, so it only wins again when nobody else is requesting.
    always_comb begin
        pick       = grant_q;
        pick_found = 1'b0;
        idx        = 0;
        cand       = '0;
        for (int unsigned k = 1; k <= SOURCE_COUNT; k++) begin
            idx  = (32'(grant_q) + k) % SOURCE_COUNT;
            cand = GW'(idx);
            if (!pick_found && in_valid[cand]) begin
                pick       = cand;
                pick_found = 1'b1;
            end
        end
    end

    // Built from the grant register, so the tag stays stable while stalled.
    assign tag_byte = TAG_BASE | DATA_WIDTH'(grant_q);

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        in_ready  = '0;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d = pick;
                    state_d = TAG_ENABLE ? TAG : STREAM;
                end
            end
            TAG: begin
                out_valid = 1'b1;
                out_data  = tag_byte;
                if (out_ready) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                out_valid         = in_valid[grant_q];
                out_data          = in_data[DATA_WIDTH*grant_q +: DATA_WIDTH];
                out_last          = in_last[grant_q];
                in_ready[grant_q] = out_ready;
                if (in_valid[grant_q] && out_ready && in_last[grant_q]) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= GW'(SOURCE_COUNT - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
        end
    end

    assign grant_index = grant_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_packet_stream_arbiter.sv
// Self-checking bench for packet_stream_arbiter: directed scenarios plus a randomized
// run checked against a packet-level round-robin reference model.
module tb_packet_stream_arbiter;

    localparam int N    = 3;
    localparam int DW   = 8;
    localparam int GW   = 2;
    localparam logic [7:0] TAGB = 8'hA0;
    localparam int HIST = 16384;

    typedef struct { logic [7:0] data; bit last; } beat_t;
    typedef struct { logic [7:0] data; bit last; int cyc; } obs_t;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [DW*N-1:0] in_data;
    logic [N-1:0]  in_valid, in_last;
    logic [N-1:0]  in_ready, in_ready_nt;
    logic [DW-1:0] out_data, out_data_nt;
    logic          out_valid, out_valid_nt, out_last, out_last_nt;
    logic          out_ready;
    logic [GW-1:0] grant_index, grant_index_nt;
    logic          busy, busy_nt;

    beat_t src_q [N][$];
    beat_t exp_q [N][$];
    obs_t  obs_q [$];
    bit    presenting [N];
    bit    acc [N];
    int    cyc = 0;
    int    gap_pct = 0;
    int    rdy_mode = 1;
    bit    sel_nt = 1'b0;
    logic [N-1:0] iv_hist [HIST];
    bit    ov_hist [HIST];
    int    checks = 0;
    int    errors = 0;

    logic          mon_ov, mon_ol;
    logic [DW-1:0] mon_od;
    logic [N-1:0]  mon_ir;
    assign mon_ov = sel_nt ? out_valid_nt : out_valid;
    assign mon_ol = sel_nt ? out_last_nt  : out_last;
    assign mon_od = sel_nt ? out_data_nt  : out_data;
    assign mon_ir = sel_nt ? in_ready_nt  : in_ready;

    always #5 clock = ~clock;

    packet_stream_arbiter #(.SOURCE_COUNT(N), .DATA_WIDTH(DW), .TAG_ENABLE(1'b1), .TAG_BASE(TAGB)) dut (
        .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .in_last(in_last), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .grant_index(grant_index), .busy(busy)
    );

    packet_stream_arbiter #(.SOURCE_COUNT(N), .DATA_WIDTH(DW), .TAG_ENABLE(1'b0), .TAG_BASE(TAGB)) dut_nt (
        .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_nt), .in_last(in_last), .out_data(out_data_nt), .out_valid(out_valid_nt),
        .out_ready(out_ready), .out_last(out_last_nt), .grant_index(grant_index_nt), .busy(busy_nt)
    );

    // Source and sink driver: a presented beat is held until it is accepted.
    initial begin
        in_valid  = '0;
        in_last   = '0;
        in_data   = '0;
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) presenting[i] = 1'b0;
        forever begin
            @(posedge clock);
            cyc++;
            #1;
            for (int i = 0; i < N; i++) begin
                if (acc[i] && src_q[i].size() > 0) begin
                    void'(src_q[i].pop_front());
                    presenting[i] = 1'b0;
                end
                if (src_q[i].size() == 0) presenting[i] = 1'b0;
                if (!presenting[i] && src_q[i].size() > 0 && $urandom_range(99) >= gap_pct)
                    presenting[i] = 1'b1;
                in_valid[i] = presenting[i];
                in_data[DW*i +: DW] = presenting[i] ? src_q[i][0].data : 8'($urandom_range(255));
                in_last[i] = presenting[i] ? src_q[i][0].last : 1'($urandom_range(1));
            end
            case (rdy_mode)
                0: out_ready = 1'b0;
                1: out_ready = 1'b1;
                2: out_ready = ~out_ready;
                default: out_ready = 1'($urandom_range(1));
            endcase
        end
    end

    // Monitor: records accepted output beats and per-cycle request history.
    initial begin
        for (int i = 0; i < N; i++) acc[i] = 1'b0;
        forever begin
            @(negedge clock);
            for (int i = 0; i < N; i++) acc[i] = !reset && in_valid[i] && mon_ir[i];
            if (!reset && mon_ov && out_ready) obs_q.push_back('{mon_od, mon_ol, cyc});
            if (cyc < HIST) begin
                iv_hist[cyc] = in_valid;
                ov_hist[cyc] = mon_ov;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_beat(input int s, input logic [7:0] d, input bit l);
        src_q[s].push_back('{d, l});
    endtask

    task automatic do_reset();
        @(posedge clock);
        #2;
        reset = 1'b1;
        for (int i = 0; i < N; i++) src_q[i].delete();
        @(posedge clock);
        #2;
        reset = 1'b0;
        obs_q.delete();
    endtask

    task automatic wait_obs(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(posedge clock);
            if (obs_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rdy_mode = 1;
        gap_pct  = 0;
        sel_nt   = 1'b0;
        do_reset();
        @(negedge clock);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 3'b000) begin errors++; $display("FAIL reset_in_ready: got %b expected 000", in_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (grant_index !== 2'd2) begin errors++; $display("FAIL reset_grant: got %0d expected 2", grant_index); end
        checks++; if (grant_index_nt !== 2'd2) begin errors++; $display("FAIL reset_grant_nt: got %0d expected 2", grant_index_nt); end
    endtask

    task automatic test_single_source();
        logic [7:0] ed [3] = '{8'hA1, 8'h11, 8'h12};
        bit el [3] = '{1'b0, 1'b0, 1'b1};
        bit seen = 1'b0, done = 1'b0;
        rdy_mode = 1;
        do_reset();
        push_beat(1, 8'h11, 1'b0);
        push_beat(1, 8'h12, 1'b1);
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clock);
            if (seen) begin
                checks++;
                if (busy !== 1'b0 || out_valid !== 1'b0) begin
                    errors++; $display("FAIL single_busy_fall: got busy=%b valid=%b expected 0 0", busy, out_valid);
                end
                done = 1'b1;
            end else if (out_valid && out_ready && out_last) begin
                checks++;
                if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_last: got %b expected 1", busy); end
                seen = 1'b1;
            end
        end
        checks++; if (!done) begin errors++; $display("FAIL single_timeout: got no last beat expected one"); end
        checks++;
        if (obs_q.size() != 3) begin
            errors++; $display("FAIL single_count: got %0d expected 3", obs_q.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obs_q[k].data !== ed[k] || obs_q[k].last !== el[k]) begin
                    errors++; $display("FAIL single_beat%0d: got %h/%b expected %h/%b", k, obs_q[k].data, obs_q[k].last, ed[k], el[k]);
                end
            end
        end
        checks++; if (grant_index !== 2'd1) begin errors++; $display("FAIL single_grant: got %0d expected 1", grant_index); end
    endtask

    task automatic test_round_robin();
        bit ok;
        logic [7:0] et, ev;
        int s;
        rdy_mode = 1;
        do_reset();
        for (int r = 0; r < 3; r++)
            for (int i = 0; i < N; i++) push_beat(i, 8'((i + 1) << 4), 1'b1);
        wait_obs(18, 200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rr_timeout: got %0d beats expected 18", obs_q.size()); end
        if (ok) begin
            for (int k = 0; k < 9; k++) begin
                s  = k % N;
                et = TAGB | 8'(s);
                ev = 8'((s + 1) << 4);
                checks++;
                if (obs_q[2*k].data !== et || obs_q[2*k].last !== 1'b0) begin
                    errors++; $display("FAIL rr_tag%0d: got %h expected %h", k, obs_q[2*k].data, et);
                end
                checks++;
                if (obs_q[2*k+1].data !== ev || obs_q[2*k+1].last !== 1'b1) begin
                    errors++; $display("FAIL rr_data%0d: got %h/%b expected %h/1", k, obs_q[2*k+1].data, obs_q[2*k+1].last, ev);
                end
                if (k > 0) begin
                    checks++;
                    if (obs_q[2*k].cyc - obs_q[2*k-1].cyc != 2) begin
                        errors++; $display("FAIL rr_gap%0d: got %0d cycles expected 2", k, obs_q[2*k].cyc - obs_q[2*k-1].cyc);
                    end
                end
            end
        end
    endtask

    task automatic test_no_interleave();
        bit ok, got03 = 1'b0;
        logic [7:0] ed [7] = '{8'hA0, 8'h01, 8'h02, 8'h03, 8'hA2, 8'h21, 8'h22};
        rdy_mode = 1;
        do_reset();
        push_beat(0, 8'h01, 1'b0); push_beat(0, 8'h02, 1'b0); push_beat(0, 8'h03, 1'b1);
        push_beat(2, 8'h21, 1'b0); push_beat(2, 8'h22, 1'b1);
        for (int c = 0; c < 40 && !got03; c++) begin
            @(negedge clock);
            checks++;
            if (in_ready[2] !== 1'b0) begin errors++; $display("FAIL noint_ready2: got %b expected 0", in_ready[2]); end
            if (out_valid && out_ready && out_last && out_data == 8'h03) got03 = 1'b1;
        end
        checks++; if (!got03) begin errors++; $display("FAIL noint_timeout: got no 03 expected 03"); end
        wait_obs(7, 60, ok);
        checks++;
        if (!ok || obs_q.size() != 7) begin
            errors++; $display("FAIL noint_count: got %0d expected 7", obs_q.size());
        end else begin
            for (int k = 0; k < 7; k++) begin
                checks++;
                if (obs_q[k].data !== ed[k] || obs_q[k].last !== (k == 3 || k == 6)) begin
                    errors++; $display("FAIL noint_beat%0d: got %h/%b expected %h", k, obs_q[k].data, obs_q[k].last, ed[k]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        bit stalled = 1'b0, tag_stall = 1'b0;
        logic [7:0] pd = '0;
        logic [7:0] ed [5] = '{8'hA1, 8'h41, 8'h42, 8'h43, 8'h44};
        rdy_mode = 0;
        do_reset();
        rdy_mode = 2;
        for (int k = 0; k < 4; k++) push_beat(1, 8'h41 + 8'(k), k == 3);
        for (int c = 0; c < 60 && obs_q.size() < 5; c++) begin
            @(negedge clock);
            if (stalled) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== pd) begin
                    errors++; $display("FAIL bp_stable: got %b/%h expected 1/%h", out_valid, out_data, pd);
                end
            end
            stalled = out_valid && !out_ready;
            pd      = out_data;
            if (stalled && busy && in_ready == '0 && out_data == 8'hA1) tag_stall = 1'b1;
        end
        checks++; if (!tag_stall) begin errors++; $display("FAIL bp_tag_stall: got 0 expected 1"); end
        checks++;
        if (obs_q.size() != 5) begin
            errors++; $display("FAIL bp_count: got %0d expected 5", obs_q.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (obs_q[k].data !== ed[k] || obs_q[k].last !== (k == 4)) begin
                    errors++; $display("FAIL bp_beat%0d: got %h/%b expected %h", k, obs_q[k].data, obs_q[k].last, ed[k]);
                end
            end
        end
    endtask

    task automatic test_notag_wrap();
        bit ok;
        rdy_mode = 1;
        sel_nt   = 1'b1;
        do_reset();
        push_beat(0, 8'h0A, 1'b1);
        push_beat(2, 8'h2A, 1'b1);
        wait_obs(2, 40, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL notag_timeout: got %0d beats expected 2", obs_q.size());
        end else begin
            checks++; if (obs_q[0].data !== 8'h0A) begin errors++; $display("FAIL notag_first: got %h expected 0a", obs_q[0].data); end
            checks++; if (obs_q[1].data !== 8'h2A) begin errors++; $display("FAIL notag_second: got %h expected 2a", obs_q[1].data); end
            checks++;
            if (obs_q[1].cyc - obs_q[0].cyc != 2) begin
                errors++; $display("FAIL notag_gap: got %0d expected 2", obs_q[1].cyc - obs_q[0].cyc);
            end
        end
        @(posedge clock);
        checks++; if (grant_index_nt !== 2'd2) begin errors++; $display("FAIL notag_grant: got %0d expected 2", grant_index_nt); end
        sel_nt = 1'b0;
    endtask

    task automatic test_reset_midpacket();
        bit ok;
        logic [7:0] ed [6] = '{8'hA1, 8'h61, 8'h62, 8'hA1, 8'h63, 8'h64};
        rdy_mode = 1;
        do_reset();
        for (int k = 0; k < 4; k++) push_beat(1, 8'h61 + 8'(k), k == 3);
        wait_obs(2, 40, ok);
        #2;
        rdy_mode = 0;
        @(posedge clock);
        #2;
        reset = 1'b1;
        @(posedge clock);
        #2;
        reset = 1'b0;
        @(negedge clock);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b expected 0", busy); end
        checks++; if (in_ready !== 3'b000) begin errors++; $display("FAIL rmid_ready: got %b expected 000", in_ready); end
        checks++; if (grant_index !== 2'd2) begin errors++; $display("FAIL rmid_grant: got %0d expected 2", grant_index); end
        rdy_mode = 1;
        wait_obs(6, 60, ok);
        checks++;
        if (!ok || obs_q.size() != 6) begin
            errors++; $display("FAIL rmid_count: got %0d expected 6", obs_q.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                checks++;
                if (obs_q[k].data !== ed[k] || obs_q[k].last !== (k == 5)) begin
                    errors++; $display("FAIL rmid_beat%0d: got %h/%b expected %h", k, obs_q[k].data, obs_q[k].last, ed[k]);
                end
            end
        end
    endtask

    task automatic test_random();
        bit ok;
        int total = 0, base, k, a, prev, exp_src, s, len;
        logic [7:0] d, et;
        beat_t b, e;
        rdy_mode = 3;
        gap_pct  = 30;
        do_reset();
        base = cyc;
        for (int i = 0; i < N; i++) begin
            exp_q[i].delete();
            for (int p = 0; p < 6; p++) begin
                len = $urandom_range(1, 4);
                for (int j = 0; j < len; j++) begin
                    b = '{8'($urandom_range(255)), j == len - 1};
                    src_q[i].push_back(b);
                    exp_q[i].push_back(b);
                    total++;
                end
                total++;
            end
        end
        wait_obs(total, 4000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rand_timeout: got %0d beats expected %0d", obs_q.size(), total); end
        prev = N - 1;
        k = 0;
        while (ok && k < obs_q.size()) begin
            a = obs_q[k].cyc - 1;
            while (a > base && ov_hist[a]) a--;
            exp_src = -1;
            for (int j = 1; j <= N; j++) begin
                s = (prev + j) % N;
                if (exp_src < 0 && iv_hist[a][s]) exp_src = s;
            end
            et = TAGB | 8'(exp_src);
            d  = obs_q[k].data;
            checks++;
            if (d !== et || obs_q[k].last !== 1'b0) begin
                errors++; $display("FAIL rand_tag@%0d: got %h expected %h", obs_q[k].cyc, d, et);
            end
            if (d[7:2] !== TAGB[7:2] || d[1:0] >= 2'(N)) break;
            s = int'(d[1:0]);
            prev = s;
            k++;
            do begin
                if (k >= obs_q.size() || exp_q[s].size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rand_underrun: got no beat expected data for source %0d", s);
                    k = obs_q.size();
                    break;
                end
                e = exp_q[s].pop_front();
                checks++;
                if (obs_q[k].data !== e.data || obs_q[k].last !== e.last) begin
                    errors++; $display("FAIL rand_data@%0d: got %h/%b expected %h/%b", obs_q[k].cyc, obs_q[k].data, obs_q[k].last, e.data, e.last);
                end
                k++;
            end while (!e.last);
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (exp_q[i].size() != 0) begin errors++; $display("FAIL rand_left%0d: got %0d beats left expected 0", i, exp_q[i].size()); end
        end
        gap_pct = 0;
    endtask

    initial begin
        test_reset();
        test_single_source();
        test_round_robin();
        test_no_interleave();
        test_backpressure();
        test_notag_wrap();
        test_reset_midpacket();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
